irq_controller: RTL and testbench

- Memory-mapped interrupt controller upstream of the CPU.
- Collects 8 peripheral request lines, latches them as pending, applies a mask, and picks one winner by fixed priority.
- Presents the winner to the CPU `interrupts` input as a one-hot vector.
- The CPU acknowledges by reading a vector register and ends service with an EOI write, both over the shared `data_bus`/`address_bus`/`r`/`w` bus.

---
 rtl/irq_controller.sv | 141 ++++++++++++++
 tb/tb_irq_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with a 4-register memory-mapped CPU interface.
// Define IRQ_CONTROLLER_EDGE_EN to latch pending on rising edges instead of levels.

module irq_controller_lane (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic clr,
  output logic pend_q,
  output logic pend_d
);
  logic set;

`ifdef IRQ_CONTROLLER_EDGE_EN
  logic prev_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= line;
  assign set = line & ~prev_q;
`else
  assign set = line;
`endif

  // A request arriving in the same cycle as a clear wins.
  assign pend_d = (pend_q & ~clr) | set;

  always_ff @(posedge clk or negedge reset)
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= pend_d;
endmodule

module irq_controller #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          NUM_IRQ   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        address_bus,
  inout  wire  [15:0]        data_bus,
  input  logic               r,
  input  logic               w,
  input  logic [NUM_IRQ-1:0] irq_lines,
  output logic [NUM_IRQ-1:0] interrupts
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [2:0]         in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, clr, req;
  logic [2:0]         win;
  logic [15:0]        off_full, rdata;
  logic [1:0]         off;
  logic               hit, wr, rd, ack;

  assign off_full = address_bus - BASE_ADDR;
  assign hit      = (off_full[15:2] == 14'd0);
  assign off      = off_full[1:0];
  assign wr       = w & hit;
  // A simultaneous write takes the bus cycle, so the read is dropped entirely.
  assign rd       = r & ~w & hit;
  assign req      = pend_q & mask_q;
  assign ack      = rd && (off == 2'd2) && (state_q == S_REQ);

  always_comb begin
    win = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (req[i]) win = 3'(i);
  end

  always_comb begin
    clr = '0;
    if (wr && off == 2'd1) clr = data_bus[NUM_IRQ-1:0];
    if (ack) clr[win] = 1'b1;
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
    irq_controller_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .line   (irq_lines[i]),
      .clr    (clr[i]),
      .pend_q (pend_q[i]),
      .pend_d (pend_d[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    mask_d       = mask_q;
    if (wr && off == 2'd0) mask_d = data_bus[NUM_IRQ-1:0];
    case (state_q)
      S_IDLE:    if (|req) state_d = S_REQ;
      S_REQ: begin
        if (ack) begin
          state_d      = S_SERVICE;
          in_service_d = win;
        end else if (~|(pend_d & mask_d)) begin
          // Request withdrawn by a mask or W1C write before acknowledge.
          state_d = S_IDLE;
        end
      end
      S_SERVICE: if (wr && off == 2'd3) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    irq_d = '0;
    if (state_q == S_REQ) irq_d[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      irq_q        <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
    end

  assign interrupts = irq_q;

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = {8'h00, mask_q};
      2'd1: rdata = {8'h00, pend_q};
      2'd2: rdata = (state_q == S_REQ) ? {1'b1, 12'h000, win} : 16'h0000;
      default: rdata = 16'h0000;
    endcase
  end

  assign data_bus = rd ? rdata : 16'bz;

  logic unused_bits;
  assign unused_bits = ^{data_bus[15:NUM_IRQ], in_service_q};
endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a behavioural model.

module tb_irq_controller;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam int IDLE = 0, REQ = 1, SERV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        r, w;
  logic [7:0]  irq_lines;
  wire  [7:0]  interrupts;
  wire  [15:0] data_bus;
  logic [15:0] tb_data;
  logic        tb_drv;

  assign data_bus = tb_drv ? tb_data : 16'bz;
  always #5 clk = ~clk;

  irq_controller #(.BASE_ADDR(BASE), .NUM_IRQ(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .address_bus (addr),
    .data_bus    (data_bus),
    .r           (r),
    .w           (w),
    .irq_lines   (irq_lines),
    .interrupts  (interrupts)
  );

  int checks = 0, errors = 0;

  logic [7:0] m_mask, m_pend, m_irq, m_prev;
  int         m_st;

  function automatic int winner(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] m_read(input int off);
    case (off)
      0: return {8'h00, m_mask};
      1: return {8'h00, m_pend};
      2: return (m_st == REQ) ? (16'h8000 | 16'(winner(m_pend & m_mask))) : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_clear();
    m_mask = 0; m_pend = 0; m_irq = 0; m_prev = 0; m_st = IDLE;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    int a, off;
    bit hit, wr, rd, ack;
    logic [7:0] req, set, n_mask, n_pend, n_irq, cur_irq;
    int n_st;
    a = int'(addr);
    hit = (a >= int'(BASE)) && (a <= int'(BASE) + 3);
    off = a - int'(BASE);
    wr = w && hit;
    rd = r && !w && hit;
    req = m_pend & m_mask;
    ack = rd && off == 2 && m_st == REQ;
    cur_irq = irq_lines;
`ifdef IRQ_CONTROLLER_EDGE_EN
    set = irq_lines & ~m_prev;
`else
    set = irq_lines;
`endif
    n_mask = (wr && off == 0) ? tb_data[7:0] : m_mask;
    n_pend = m_pend;
    if (wr && off == 1) n_pend = n_pend & ~tb_data[7:0];
    if (ack) n_pend[winner(req)] = 1'b0;
    n_pend = n_pend | set;
    n_st = m_st;
    if (m_st == IDLE && req != 0) n_st = REQ;
    else if (m_st == REQ && ack) n_st = SERV;
    else if (m_st == REQ && (n_pend & n_mask) == 0) n_st = IDLE;
    else if (m_st == SERV && wr && off == 3) n_st = IDLE;
    n_irq = (m_st == REQ) ? 8'(1 << winner(req)) : 8'h00;
    @(posedge clk);
    if (!reset) m_clear();
    else begin
      m_mask = n_mask; m_pend = n_pend; m_st = n_st; m_irq = n_irq; m_prev = cur_irq;
    end
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [15:0] d);
    addr = 16'(int'(BASE) + off); tb_data = d; tb_drv = 1'b1; w = 1'b1;
    tick();
    w = 1'b0; tb_drv = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd_reg(input string tag, input int off, input logic [15:0] exp);
    addr = 16'(int'(BASE) + off); r = 1'b1;
    #1;
    check(tag, data_bus, exp);
    tick();
    r = 1'b0; addr = 16'h0000;
  endtask

  task automatic chk_irq(input string tag, input logic [7:0] exp);
    check(tag, {8'h00, interrupts}, {8'h00, exp});
  endtask

  initial begin
    reset = 1'b0; r = 0; w = 0; addr = 0; irq_lines = 0; tb_data = 0; tb_drv = 0;
    m_clear();
    tick(); tick();
    reset = 1'b1;

    // Reach SERVICE, then reset asynchronously with every line high.
    wr_reg(0, 16'h00FF);
    irq_lines = 8'h01; tick(); irq_lines = 0; tick(); tick();
    chk_irq("pre_irq", 8'h01);
    rd_reg("pre_vec", 2, 16'h8000);
    irq_lines = 8'hFF;
    #2 reset = 1'b0; m_clear();
    #1 chk_irq("rst_irq", 8'h00);
    rd_reg("rst_mask", 0, 16'h0000);
    reset = 1'b1;
    tick();
    rd_reg("rst_pend", 1, 16'h00FF);
    chk_irq("rst_idle", 8'h00);
    irq_lines = 0;
    wr_reg(1, 16'h00FF);
    wr_reg(0, 16'h00FF);
    tick(); tick();
    chk_irq("clean", 8'h00);

    // Priority: bit 2 beats bit 5.
    irq_lines = 8'b0010_0100; tick(); irq_lines = 0; tick(); tick();
    chk_irq("prio_irq", 8'h04);
    rd_reg("prio_vec", 2, 16'h8002);
    tick();
    chk_irq("prio_svc", 8'h00);
    rd_reg("prio_pend", 1, 16'h0020);
    wr_reg(3, 16'h0000); tick(); tick();
    chk_irq("prio_next", 8'h20);
    rd_reg("prio_vec2", 2, 16'h8005);
    wr_reg(3, 16'h0000); tick(); tick();
    chk_irq("prio_done", 8'h00);

    // Masking.
    wr_reg(0, 16'h00FE);
    irq_lines = 8'h01; tick(); irq_lines = 0; tick(); tick();
    chk_irq("mask_hold", 8'h00);
    rd_reg("mask_pend", 1, 16'h0001);
    wr_reg(0, 16'hFFFF);
    rd_reg("mask_rd", 0, 16'h00FF);
    tick();
    chk_irq("mask_open", 8'h01);
    rd_reg("mask_vec", 2, 16'h8000);
    wr_reg(3, 16'h0000); tick(); tick();

    // W1C aborts a request before acknowledge.
    irq_lines = 8'h08; tick(); irq_lines = 0; tick(); tick();
    chk_irq("w1c_irq", 8'h08);
    wr_reg(1, 16'h0008); tick();
    chk_irq("w1c_abort", 8'h00);
    rd_reg("w1c_vec", 2, 16'h0000);

`ifndef IRQ_CONTROLLER_EDGE_EN
    // Level mode: a held line beats the W1C clear.
    irq_lines = 8'h02; tick(); tick(); tick();
    wr_reg(1, 16'h0002);
    rd_reg("race_pend", 1, 16'h0002);
    irq_lines = 0;
    rd_reg("race_vec", 2, 16'h8001);
    wr_reg(3, 16'h0000); tick(); tick();
    chk_irq("race_done", 8'h00);
    rd_reg("race_clr", 1, 16'h0000);
`else
    // Edge mode: a held line requests once only.
    irq_lines = 8'h10; tick(); tick(); tick();
    chk_irq("edge_irq", 8'h10);
    rd_reg("edge_vec", 2, 16'h8004);
    wr_reg(3, 16'h0000);
    repeat (5) tick();
    chk_irq("edge_once", 8'h00);
    rd_reg("edge_pend", 1, 16'h0000);
    irq_lines = 0; tick(); irq_lines = 8'h10; tick(); tick(); tick();
    chk_irq("edge_again", 8'h10);
    rd_reg("edge_vec2", 2, 16'h8004);
    irq_lines = 0;
    wr_reg(3, 16'h0000); tick(); tick();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int op, off;
      irq_lines = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      op = $urandom_range(0, 9);
      off = $urandom_range(0, 3);
      case (op)
        3: rd_reg("rnd_rd", off, m_read(off));
        4: rd_reg("rnd_vec", 2, m_read(2));
        5: wr_reg(0, 16'($urandom) | 16'($urandom));
        6: wr_reg(1, 16'($urandom) & 16'($urandom));
        7: wr_reg(3, 16'($urandom));
        8: begin
          addr = ($urandom_range(0, 1) != 0) ? BASE + 16'd4 : BASE - 16'd1;
          tb_data = 16'($urandom); tb_drv = 1; w = 1;
          tick();
          w = 0; tb_drv = 0; addr = 0;
        end
        9: begin
          addr = 16'(int'(BASE) + off); tb_data = 16'($urandom); tb_drv = 1; r = 1; w = 1;
          tick();
          r = 0; w = 0; tb_drv = 0; addr = 0;
        end
        default: tick();
      endcase
      chk_irq("rnd_irq", m_irq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
